// File: rtl/song_player.sv
// Autonomous Ode to Joy sequencer: plays a fixed 15-note phrase with timed notes and gaps.
// Optional SONG_LOOP_EN: wrap from the last note back to the first instead of stopping.
module song_player #(
    parameter int TICK_DIV   = 100000,
    parameter int NOTE_TICKS = 4,
    parameter int GAP_TICKS  = 1
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       start,
    input  logic       stop,
    output logic [3:0] note,
    output logic [7:0] Led,
    output logic       busy,
    output logic       done,
    output logic [3:0] index
);

    localparam logic [3:0] NOTE_NONE = 4'd0;
    localparam logic [3:0] NOTE_C4   = 4'd1;
    localparam logic [3:0] NOTE_D    = 4'd2;
    localparam logic [3:0] NOTE_E    = 4'd3;
    localparam logic [3:0] NOTE_F    = 4'd4;
    localparam logic [3:0] NOTE_G    = 4'd5;

    localparam logic [7:0] LED_C4 = 8'b0000_0001;
    localparam logic [7:0] LED_D  = 8'b0000_0010;
    localparam logic [7:0] LED_E  = 8'b0000_0100;
    localparam logic [7:0] LED_F  = 8'b0000_1000;
    localparam logic [7:0] LED_G  = 8'b0001_0000;

    localparam logic [23:0] DIV_LAST   = 24'(TICK_DIV - 1);
    localparam logic [7:0]  NOTE_LAST  = 8'(NOTE_TICKS - 1);
    localparam logic [7:0]  GAP_LAST   = 8'(GAP_TICKS - 1);
    localparam logic [3:0]  LAST_INDEX = 4'd14;

    typedef enum logic [1:0] {IDLE, NOTE, GAP} state_t;

    function automatic logic [3:0] song_rom(input logic [3:0] i);
        case (i)
            4'd0, 4'd1, 4'd6, 4'd11, 4'd12: song_rom = NOTE_E;
            4'd2, 4'd5:                     song_rom = NOTE_F;
            4'd3, 4'd4:                     song_rom = NOTE_G;
            4'd7, 4'd10, 4'd13, 4'd14:      song_rom = NOTE_D;
            4'd8, 4'd9:                     song_rom = NOTE_C4;
            default:                        song_rom = NOTE_NONE;
        endcase
    endfunction

    function automatic logic [7:0] led_pattern(input logic [3:0] code);
        case (code)
            NOTE_C4: led_pattern = LED_C4;
            NOTE_D:  led_pattern = LED_D;
            NOTE_E:  led_pattern = LED_E;
            NOTE_F:  led_pattern = LED_F;
            NOTE_G:  led_pattern = LED_G;
            default: led_pattern = 8'h00;
        endcase
    endfunction

    state_t      state;
    logic [23:0] prescale;
    logic [7:0]  tick_cnt;
    logic        tick;

    assign tick = (prescale == DIV_LAST);

    // Phase changes happen only on a tick, so the prescaler is already wrapping to 0 on entry.
    always_ff @(posedge CLK) begin
        // NOTE: every register here uses <= so all updates see the pre-edge values of their peers.
        if (RESET) begin
            state    <= IDLE;
            prescale <= '0;
            tick_cnt <= '0;
            note     <= NOTE_NONE;
            Led      <= LED_E;
            busy     <= 1'b0;
            done     <= 1'b0;
            index    <= '0;
        end else begin
            done     <= 1'b0;
            prescale <= tick ? '0 : prescale + 24'd1;
            if (stop) begin
                state    <= IDLE;
                prescale <= '0;
                tick_cnt <= '0;
                note     <= NOTE_NONE;
                Led      <= LED_E;
                busy     <= 1'b0;
                index    <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        prescale <= '0;
                        if (start) begin
                            state    <= NOTE;
                            tick_cnt <= '0;
                            note     <= song_rom(4'd0);
                            Led      <= led_pattern(song_rom(4'd0));
                            busy     <= 1'b1;
                            index    <= '0;
                        end
                    end
                    NOTE: begin
                        if (tick) begin
                            if (tick_cnt == NOTE_LAST) begin
                                state    <= GAP;
                                tick_cnt <= '0;
                                note     <= NOTE_NONE;
                            end else begin
                                tick_cnt <= tick_cnt + 8'd1;
                            end
                        end
                    end
                    GAP: begin
                        if (tick) begin
                            if (tick_cnt == GAP_LAST) begin
                                tick_cnt <= '0;
                                if (index == LAST_INDEX) begin
                                    done <= 1'b1;
`ifdef SONG_LOOP_EN
                                    state <= NOTE;
                                    index <= '0;
                                    note  <= song_rom(4'd0);
                                    Led   <= led_pattern(song_rom(4'd0));
`else
                                    state <= IDLE;
                                    index <= '0;
                                    Led   <= LED_E;
                                    busy  <= 1'b0;
`endif
                                end else begin
                                    state <= NOTE;
                                    index <= index + 4'd1;
                                    note  <= song_rom(index + 4'd1);
                                    Led   <= led_pattern(song_rom(index + 4'd1));
                                end
                            end else begin
                                tick_cnt <= tick_cnt + 8'd1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_song_player.sv
// Self-checking bench for song_player: vector table, directed pass/abort/corner runs, random run vs model.
module tb_song_player;

    localparam int TD  = 4;
    localparam int NT  = 3;
    localparam int GT  = 1;
    localparam int P   = (NT + GT) * TD;
    localparam int LEN = 15;

    localparam logic [3:0] N_NONE = 4'd0;
    localparam logic [3:0] N_C4   = 4'd1;
    localparam logic [3:0] N_D    = 4'd2;
    localparam logic [3:0] N_E    = 4'd3;
    localparam logic [3:0] N_F    = 4'd4;
    localparam logic [3:0] N_G    = 4'd5;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [3:0] note;
    logic [7:0] Led;
    logic       busy;
    logic       done;
    logic [3:0] index;

    always #5 CLK = ~CLK;

    song_player #(.TICK_DIV(TD), .NOTE_TICKS(NT), .GAP_TICKS(GT)) dut (
        .CLK(CLK), .RESET(RESET), .start(start), .stop(stop),
        .note(note), .Led(Led), .busy(busy), .done(done), .index(index)
    );

    int total = 0;
    int bad = 0;
    int edge_no = 0;
    logic [3:0] song [LEN];

    // Reference model: elapsed edges since the first note appeared.
    bit m_active = 1'b0;
    int m_d = 0;
    bit m_done = 1'b0;

    function automatic logic [7:0] led_of(input logic [3:0] code);
        case (code)
            N_C4:    return 8'h01;
            N_D:     return 8'h02;
            N_E:     return 8'h04;
            N_F:     return 8'h08;
            N_G:     return 8'h10;
            default: return 8'h00;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s edge=%0d got=%0h want=%0h", name, edge_no, act, exp);
        end
    endtask

    task automatic model_update(input logic r, input logic s, input logic p);
        m_done = 1'b0;
        if (r || p) begin
            m_active = 1'b0;
        end else if (!m_active) begin
            if (s) begin
                m_active = 1'b1;
                m_d = 0;
            end
        end else begin
            m_d++;
            if (m_d == LEN * P) begin
                m_done = 1'b1;
`ifdef SONG_LOOP_EN
                m_d = 0;
`else
                m_active = 1'b0;
`endif
            end
        end
    endtask

    task automatic step(input logic r, input logic s, input logic p);
        @(negedge CLK);
        RESET = r;
        start = s;
        stop = p;
        @(posedge CLK);
        edge_no++;
        model_update(r, s, p);
        #1;
    endtask

    task automatic check_model();
        logic [3:0] e_note, e_idx;
        logic [7:0] e_led;
        logic e_busy;
        if (m_active) begin
            e_idx  = 4'(m_d / P);
            e_note = ((m_d % P) < NT * TD) ? song[m_d / P] : N_NONE;
            e_led  = led_of(song[m_d / P]);
            e_busy = 1'b1;
        end else begin
            e_idx = 4'd0; e_note = N_NONE; e_led = 8'h04; e_busy = 1'b0;
        end
        check("note", 32'(note), 32'(e_note));
        check("led", 32'(Led), 32'(e_led));
        check("busy", 32'(busy), 32'(e_busy));
        check("done", 32'(done), 32'(m_done));
        check("index", 32'(index), 32'(e_idx));
    endtask

    typedef struct {
        logic       r, s, p;
        logic [3:0] note;
        logic [7:0] led;
        logic       busy;
        logic [3:0] idx;
        logic       done;
    } vec_t;

    vec_t tbl [13];

    initial begin
        int k, done_cnt, done_edge;
        logic [3:0] prev_note;
        logic [3:0] seen_notes [$];
        logic [7:0] seen_leds [$];

        song = '{N_E, N_E, N_F, N_G, N_G, N_F, N_E, N_D, N_C4, N_C4, N_D, N_E, N_E, N_D, N_D};

        // r s p : note led busy idx done
        tbl[0]  = '{1, 0, 0, N_NONE, 8'h04, 0, 0, 0};
        tbl[1]  = '{1, 0, 0, N_NONE, 8'h04, 0, 0, 0};
        tbl[2]  = '{1, 0, 0, N_NONE, 8'h04, 0, 0, 0};
        tbl[3]  = '{0, 1, 1, N_NONE, 8'h04, 0, 0, 0};
        tbl[4]  = '{0, 0, 0, N_NONE, 8'h04, 0, 0, 0};
        tbl[5]  = '{0, 1, 0, N_E,    8'h04, 1, 0, 0};
        tbl[6]  = '{0, 0, 0, N_E,    8'h04, 1, 0, 0};
        tbl[7]  = '{0, 1, 1, N_NONE, 8'h04, 0, 0, 0};
        tbl[8]  = '{0, 1, 0, N_E,    8'h04, 1, 0, 0};
        tbl[9]  = '{1, 1, 0, N_NONE, 8'h04, 0, 0, 0};
        tbl[10] = '{0, 0, 1, N_NONE, 8'h04, 0, 0, 0};
        tbl[11] = '{0, 1, 0, N_E,    8'h04, 1, 0, 0};
        tbl[12] = '{1, 0, 1, N_NONE, 8'h04, 0, 0, 0};

        for (int i = 0; i < 13; i++) begin
            step(tbl[i].r, tbl[i].s, tbl[i].p);
            check($sformatf("vec%0d_note", i), 32'(note), 32'(tbl[i].note));
            check($sformatf("vec%0d_led", i), 32'(Led), 32'(tbl[i].led));
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
            check($sformatf("vec%0d_index", i), 32'(index), 32'(tbl[i].idx));
            check($sformatf("vec%0d_done", i), 32'(done), 32'(tbl[i].done));
        end

        // Full pass: timing of every note/gap and the single done pulse.
        step(0, 0, 0);
        step(0, 1, 0);
        k = edge_no - 1;
        check_model();
        seen_notes.push_back(note);
        seen_leds.push_back(Led);
        prev_note = note;
        done_cnt = 0;
        done_edge = -1;
        for (int c = 0; c < LEN * P + 3; c++) begin
            step(0, 0, 0);
            check_model();
            if (done === 1'b1) begin
                done_cnt++;
                done_edge = edge_no;
            end
            if (note !== N_NONE && prev_note === N_NONE && seen_notes.size() < LEN) begin
                seen_notes.push_back(note);
                seen_leds.push_back(Led);
            end
            prev_note = note;
        end
        check("pass_done_count", 32'(done_cnt), 32'd1);
        check("pass_done_edge", 32'(done_edge), 32'(k + LEN * P + 1));
        check("pass_note_count", 32'(seen_notes.size()), 32'(LEN));
        for (int i = 0; i < LEN && i < seen_notes.size(); i++) begin
            check($sformatf("seq%0d_note", i), 32'(seen_notes[i]), 32'(song[i]));
            check($sformatf("seq%0d_led", i), 32'(seen_leds[i]), 32'(led_of(song[i])));
        end
        step(0, 0, 1);
        check_model();

        // Abort mid-NOTE at index 5, then restart.
        step(0, 1, 0);
        check_model();
        for (int c = 0; c < 5 * P + 2; c++) begin
            step(0, 0, 0);
            check_model();
        end
        check("abort_pre_index", 32'(index), 32'd5);
        check("abort_pre_note", 32'(note), 32'(N_F));
        step(0, 0, 1);
        check("abort_note", 32'(note), 32'(N_NONE));
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_index", 32'(index), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        step(0, 1, 0);
        check("restart_note", 32'(note), 32'(N_E));
        check("restart_busy", 32'(busy), 32'd1);

        // Start pulse in index 3's gap must not disturb the sequence.
        while (m_active && m_d < 3 * P + NT * TD + 1) begin
            step(0, 0, 0);
            check_model();
        end
        check("gap3_index", 32'(index), 32'd3);
        check("gap3_note", 32'(note), 32'(N_NONE));
        step(0, 1, 0);
        check_model();
        for (int c = 0; c < LEN * P; c++) begin
            step(0, 0, 0);
            check_model();
        end
        step(0, 0, 1);
        check_model();

        // Start held high through completion: restart right after done.
        for (int c = 0; c < LEN * P + 6; c++) begin
            step(0, 1, 0);
            check_model();
        end
        step(0, 0, 1);
        check_model();

        // Random run against the model.
        for (int c = 0; c < 4000; c++) begin
            step(($urandom % 500) == 0, ($urandom % 4) == 0, ($urandom % 300) == 0);
            check_model();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
